// File: rtl/sd_acq_win_gen.sv
// Multi-channel CPMG acquisition-window generator: arm on s_acq1, open a delayed
// masked window per s_acq180 echo trigger. Optional DDS phase alignment: SD_ACQ_DDS_ALIGN_EN.
module sd_acq_win_gen #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 16,
    parameter int ECHO_W     = 12,
    parameter int LONG_SHIFT = 4
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              dds,
    input  logic              s_acq1,
    input  logic              s_acq180,
    input  logic              long_opentime,
    input  logic              bb_ch,
    input  logic              sd_sacq_load,
    input  logic [3:0]        sd_sacq_choice,
    input  logic [DATA_W-1:0] sd_sacq_data,
    output logic [NUM_CH-1:0] en,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [ECHO_W-1:0] echo_cnt
);

    localparam int CNT_W = DATA_W + LONG_SHIFT;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_DELAY = 3'd2,
`ifdef SD_ACQ_DDS_ALIGN_EN
        S_ALIGN = 3'd3,
`endif
        S_OPEN  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_nxt;

    logic [DATA_W-1:0]   r_delay;
    logic [DATA_W-1:0]   r_len;
    logic [ECHO_W-1:0]   r_echoes;
    logic [NUM_CH-1:0]   r_mask;

    logic                r_acq1_d;
    logic                r_acq180_d;
    logic [DATA_W-1:0]   r_dly_cnt;
    logic [CNT_W-1:0]    r_open_cnt;
    logic                r_bb;
    logic [NUM_CH-1:0]   r_en;
    logic                r_done;
    logic                r_overrun;
    logic [ECHO_W-1:0]   r_echo_cnt;

    logic                w_acq1_rise;
    logic                w_acq1_fall;
    logic                w_trig_rise;
    logic                w_abort;
    logic                w_win_end;
    logic                w_last;
    logic                w_open_entry;
    logic [DATA_W-1:0]   w_len_nz;
    logic [CNT_W-1:0]    w_eff_len;
    logic [NUM_CH-1:0]   w_en_val;

    assign w_acq1_rise = s_acq1 & ~r_acq1_d;
    assign w_acq1_fall = ~s_acq1 & r_acq1_d;
    assign w_trig_rise = s_acq180 & ~r_acq180_d;
    assign w_abort     = (r_state != S_IDLE) && w_acq1_fall;

`ifdef SD_ACQ_DDS_ALIGN_EN
    logic r_dds_d;
    logic w_dds_rise;
    assign w_dds_rise = dds & ~r_dds_d;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) r_dds_d <= 1'b0;
        else        r_dds_d <= dds;
    end
`else
    logic w_unused_dds;
    assign w_unused_dds = dds;
`endif

    // echoes == 0 runs forever, so the count must never be allowed to match it
    assign w_last    = (r_echoes != '0) && (ECHO_W'(r_echo_cnt + 1'b1) == r_echoes);
    assign w_len_nz  = (r_len == '0) ? DATA_W'(1) : r_len;
    assign w_eff_len = long_opentime ? (CNT_W'(w_len_nz) << LONG_SHIFT) : CNT_W'(w_len_nz);
    assign w_en_val  = r_bb ? (r_mask & NUM_CH'(1)) : r_mask;

    always_comb begin
        w_nxt     = r_state;
        w_win_end = 1'b0;
        case (r_state)
            S_IDLE:  if (w_acq1_rise) w_nxt = S_ARMED;
            S_ARMED: if (w_trig_rise) w_nxt = S_DELAY;
            S_DELAY: begin
                if (r_dly_cnt == '0) begin
`ifdef SD_ACQ_DDS_ALIGN_EN
                    w_nxt = S_ALIGN;
`else
                    w_nxt = S_OPEN;
`endif
                end
            end
`ifdef SD_ACQ_DDS_ALIGN_EN
            S_ALIGN: if (w_dds_rise) w_nxt = S_OPEN;
`endif
            S_OPEN: begin
                if (r_open_cnt == '0) begin
                    w_win_end = 1'b1;
                    w_nxt     = w_last ? S_IDLE : S_ARMED;
                end
            end
            default: w_nxt = S_IDLE;
        endcase
        // abort outranks window completion: no count, no done
        if (w_abort) begin
            w_nxt     = S_IDLE;
            w_win_end = 1'b0;
        end
    end

    assign w_open_entry = (r_state != S_OPEN) && (w_nxt == S_OPEN);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_acq1_d   <= 1'b0;
            r_acq180_d <= 1'b0;
        end else begin
            r_state    <= w_nxt;
            r_acq1_d   <= s_acq1;
            r_acq180_d <= s_acq180;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_delay  <= '0;
            r_len    <= DATA_W'(1);
            r_echoes <= ECHO_W'(1);
            r_mask   <= '1;
        end else if (sd_sacq_load && (r_state == S_IDLE)) begin
            case (sd_sacq_choice)
                4'd0:    r_delay  <= sd_sacq_data;
                4'd1:    r_len    <= sd_sacq_data;
                4'd2:    r_echoes <= sd_sacq_data[ECHO_W-1:0];
                4'd3:    r_mask   <= sd_sacq_data[NUM_CH-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_dly_cnt  <= '0;
            r_open_cnt <= '0;
            r_bb       <= 1'b0;
        end else begin
            if (r_state == S_ARMED)
                r_dly_cnt <= r_delay;
            else if ((r_state == S_DELAY) && (r_dly_cnt != '0))
                r_dly_cnt <= r_dly_cnt - 1'b1;

            if (w_open_entry) begin
                r_open_cnt <= w_eff_len - 1'b1;
                r_bb       <= bb_ch;
            end else if ((r_state == S_OPEN) && (r_open_cnt != '0)) begin
                r_open_cnt <= r_open_cnt - 1'b1;
            end
        end
    end

    // en lags OPEN by one cycle, which gives the delay+2 trigger-to-enable latency
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_en       <= '0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
            r_echo_cnt <= '0;
        end else begin
            r_en   <= ((r_state == S_OPEN) && !w_abort) ? w_en_val : '0;
            r_done <= w_win_end && w_last;

            if ((r_state == S_IDLE) && w_acq1_rise) begin
                r_echo_cnt <= '0;
                r_overrun  <= 1'b0;
            end else begin
                if (w_win_end)
                    r_echo_cnt <= r_echo_cnt + 1'b1;
                if (w_trig_rise && (r_state != S_IDLE) && (r_state != S_ARMED))
                    r_overrun <= 1'b1;
            end
        end
    end

    assign en       = r_en;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign overrun  = r_overrun;
    assign echo_cnt = r_echo_cnt;

endmodule

// File: tb/tb_sd_acq_win_gen.sv
// Directed bench for sd_acq_win_gen (default build, DDS alignment disabled).
module tb_sd_acq_win_gen;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        dds = 1'b0;
    logic        s_acq1, s_acq180, long_opentime, bb_ch, sd_sacq_load;
    logic [3:0]  sd_sacq_choice;
    logic [15:0] sd_sacq_data;
    logic [1:0]  en;
    logic        busy, done, overrun;
    logic [11:0] echo_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    bit dds_en = 1'b0;

    sd_acq_win_gen #(.NUM_CH(2), .DATA_W(16), .ECHO_W(12), .LONG_SHIFT(4)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .dds(dds), .s_acq1(s_acq1), .s_acq180(s_acq180),
        .long_opentime(long_opentime), .bb_ch(bb_ch), .sd_sacq_load(sd_sacq_load),
        .sd_sacq_choice(sd_sacq_choice), .sd_sacq_data(sd_sacq_data),
        .en(en), .busy(busy), .done(done), .overrun(overrun), .echo_cnt(echo_cnt)
    );

    initial forever #5 clk_sys = ~clk_sys;

    // dds period of 10 clocks when enabled
    initial forever begin
        #50;
        if (dds_en) dds = ~dds;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic wr(input int choice, input int data);
        sd_sacq_load   = 1'b1;
        sd_sacq_choice = 4'(choice);
        sd_sacq_data   = 16'(data);
        @(negedge clk_sys);
        sd_sacq_load   = 1'b0;
    endtask

    task automatic arm();
        s_acq1 = 1'b0;
        @(negedge clk_sys);
        s_acq1 = 1'b1;
        @(negedge clk_sys);
    endtask

    // Trigger at edge 0; p2 = edge index of a second trigger, ab = edge index sampling s_acq1 low.
    task automatic fire(input int ncyc, input int p2, input int ab,
                        output int rise_at, output int hi, output int ev, output int dn);
        rise_at  = -1;
        hi       = 0;
        ev       = 0;
        dn       = 0;
        s_acq180 = 1'b1;
        for (int j = 0; j < ncyc; j++) begin
            @(posedge clk_sys);
            @(negedge clk_sys);
            if (en != 2'b00) begin
                if (rise_at < 0) begin
                    rise_at = j;
                    ev      = int'(en);
                end
                hi++;
            end
            if (done) dn++;
            s_acq180 = (j == p2 - 1);
            if (j == ab - 1) s_acq1 = 1'b0;
        end
        s_acq180 = 1'b0;
    endtask

    int r, h, e, d, dtot;

    initial begin
        rst_n = 1'b0; s_acq1 = 1'b0; s_acq180 = 1'b0; long_opentime = 1'b0; bb_ch = 1'b0;
        sd_sacq_load = 1'b0; sd_sacq_choice = '0; sd_sacq_data = '0;
        repeat (3) @(negedge clk_sys);
        chk("rst_en", int'(en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_echo_cnt", int'(echo_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk_sys);

        // reset register values: delay 0, len 1, echoes 1, mask 11
        arm();
        chk("def_busy", int'(busy), 1);
        fire(10, -1, -1, r, h, e, d);
        chk("def_rise", r, 2);
        chk("def_len", h, 1);
        chk("def_en", e, 3);
        chk("def_done", d, 1);

        // main sequence: three echoes
        wr(0, 5); wr(1, 8); wr(2, 3); wr(3, 3);
        arm();
        for (int k = 1; k <= 3; k++) begin
            fire(40, -1, -1, r, h, e, d);
            chk("seq_rise", r, 7);
            chk("seq_len", h, 8);
            chk("seq_en", e, 3);
            chk("seq_echo_cnt", int'(echo_cnt), k);
            chk("seq_done", d, (k == 3) ? 1 : 0);
        end
        chk("seq_busy_end", int'(busy), 0);

        // long window and baseband
        wr(1, 3); wr(2, 1);
        long_opentime = 1'b1; bb_ch = 1'b1;
        arm();
        fire(80, -1, -1, r, h, e, d);
        chk("long_rise", r, 7);
        chk("long_len", h, 48);
        chk("bb_en", e, 1);
        long_opentime = 1'b0; bb_ch = 1'b0;

        // delay 0 and len 0
        wr(0, 0); wr(1, 8);
        arm();
        fire(20, -1, -1, r, h, e, d);
        chk("d0_rise", r, 2);
        chk("d0_len", h, 8);
        wr(1, 0);
        arm();
        fire(20, -1, -1, r, h, e, d);
        chk("l0_rise", r, 2);
        chk("l0_len", h, 1);

        // config write ignored while ARMED
        wr(0, 5); wr(1, 8);
        arm();
        wr(0, 1);
        fire(30, -1, -1, r, h, e, d);
        chk("armed_wr_rise", r, 7);

        // overrun: second trigger during OPEN
        wr(2, 2);
        arm();
        chk("ovr_clear0", int'(overrun), 0);
        fire(30, 11, -1, r, h, e, d);
        chk("ovr_len", h, 8);
        chk("ovr_flag", int'(overrun), 1);
        chk("ovr_echo_cnt", int'(echo_cnt), 1);
        arm();
        chk("ovr_rearm", int'(overrun), 0);
        chk("ovr_rearm_cnt", int'(echo_cnt), 0);

        // abort mid-OPEN on echo 2 of 3
        wr(2, 3);
        arm();
        fire(30, -1, -1, r, h, e, d);
        chk("ab_echo1", int'(echo_cnt), 1);
        fire(30, -1, 10, r, h, e, d);
        chk("ab_len", h, 3);
        chk("ab_done", d, 0);
        chk("ab_busy", int'(busy), 0);
        chk("ab_echo_cnt", int'(echo_cnt), 1);

        // unlimited echoes
        wr(2, 0);
        arm();
        dtot = 0;
        for (int k = 0; k < 5; k++) begin
            fire(30, -1, -1, r, h, e, d);
            dtot += d;
        end
        chk("inf_done", dtot, 0);
        chk("inf_echo_cnt", int'(echo_cnt), 5);
        chk("inf_busy", int'(busy), 1);

        // dds toggling must not move the window
        wr(0, 0);
        s_acq1 = 1'b0;
        @(negedge clk_sys);
        wr(0, 2); wr(2, 1);
        dds_en = 1'b1;
        arm();
        fire(30, -1, -1, r, h, e, d);
        chk("dds_rise", r, 4);
        chk("dds_len", h, 8);
        dds_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_acq_win_gen.md
Name: sd_acq_win_gen

Overview:
- Parametrised multi-channel acquisition-window generator for the CPMG receive path; next generation of the single-enable acquisition block.
- Sequence is armed by s_acq1. Each s_acq180 trigger then opens a delayed window of programmable length on a masked set of NUM_CH enable outputs, for a programmable number of echoes.
- Configuration is loaded over the existing sd_sacq load/choice/data register interface.

Parameters:
- NUM_CH, 2, number of acquisition enable channels (1..8).
- DATA_W, 16, width of the config data bus, delay counter and length register.
- ECHO_W, 12, width of the echo-count register and echo counter.
- LONG_SHIFT, 4, left shift applied to window length when long_opentime=1.

Ports:
- clk_sys  in  1  system clock; all inputs synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- dds  in  1  DDS phase reference square wave.
- s_acq1  in  1  sequence arm level; high = sequence active.
- s_acq180  in  1  180-degree pulse marker; rising edge = echo trigger.
- long_opentime  in  1  1 = effective length is len<<LONG_SHIFT.
- bb_ch  in  1  1 = baseband mode; only en[0] may assert.
- sd_sacq_load  in  1  register write strobe, one cycle.
- sd_sacq_choice  in  4  register address.
- sd_sacq_data  in  DATA_W  register write data.
- en  out  NUM_CH  acquisition enables.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the final echo window closes.
- overrun  out  1  sticky flag: trigger arrived while not in ARMED.
- echo_cnt  out  ECHO_W  windows completed in the current sequence.

Behaviour:
- Reset (async, rst_n=0): en=0, busy=0, done=0, overrun=0, echo_cnt=0, state=IDLE. Registers reset to delay=0, len=1, echoes=1, mask=all ones.
- Registers, written on sd_sacq_load=1 in IDLE only; writes in any other state are ignored:
  - choice 0: delay.
  - choice 1: len.
  - choice 2: echoes.
  - choice 3: mask, taken from the low NUM_CH bits.
  - choices 4-15: ignored.
- Edge detection: s_acq1 and s_acq180 are registered once; rise = x & ~x_d, fall = ~x & x_d.
- States: IDLE, ARMED, DELAY, ALIGN (present only with the optional feature), OPEN.
- IDLE -> ARMED on s_acq1 rise; echo_cnt and overrun are cleared at the same time.
- ARMED -> DELAY on s_acq180 rise; delay counter loads the delay register.
- DELAY decrements each cycle and exits when the counter is 0; delay=0 exits on the next cycle.
- OPEN: en = mask, ANDed to bit 0 only when bb_ch=1. Duration is eff_len cycles, eff_len = long_opentime ? len<<LONG_SHIFT : len, held in a DATA_W+LONG_SHIFT counter. len=0 is treated as 1. long_opentime and bb_ch are sampled on entry to OPEN.
- OPEN exit: echo_cnt increments. If echo_cnt+1 == echoes, done=1 for one cycle and go to IDLE; otherwise go to ARMED.
- echoes=0 means unlimited: echo_cnt wraps modulo 2^ECHO_W, and the sequence ends only by s_acq1 fall.
- Latency without ALIGN: en rises delay+2 cycles after the first clock edge that samples s_acq180=1, and stays high exactly eff_len cycles.
- s_acq1 fall in any non-IDLE state aborts: en=0 on the next cycle, state=IDLE, no done pulse, echo_cnt holds its value.
- s_acq180 rise in DELAY, ALIGN or OPEN: trigger ignored, overrun=1 (sticky until the next arm).
- s_acq1 rise and s_acq180 rise in the same cycle while IDLE: arm only; the trigger is not counted.
- s_acq1 fall in the same cycle as OPEN completion: abort takes priority, so no done pulse and no echo_cnt increment.

Optional Feature:
- Macro SD_ACQ_DDS_ALIGN_EN.
- Defined: after DELAY the FSM enters ALIGN and waits for a dds rising edge (registered dds, rise detected as for s_acq180), then enters OPEN on the following cycle. A s_acq1 fall aborts from ALIGN.
- Not defined: ALIGN state and dds register are removed, dds is unused, and DELAY goes directly to OPEN.

Test Plan:
- Reset, then write delay=5, len=8, echoes=3, mask=2'b11; arm; three s_acq180 pulses 40 cycles apart -> each window: en=2'b11 for 8 cycles starting 7 cycles after the trigger sample; echo_cnt 1,2,3; done pulses once after the third window; busy drops with done.
- long_opentime=1, len=3, LONG_SHIFT=4 -> window 48 cycles. bb_ch=1, mask=2'b11 -> en=2'b01.
- Edge cases, checked separately: delay=0 gives en 2 cycles after the trigger; len=0 gives a 1-cycle window; write choice 0 while ARMED leaves delay unchanged.
- Second s_acq180 during OPEN -> window length unchanged, overrun=1, echo_cnt counts only once; re-arm clears overrun.
- s_acq1 falls mid-OPEN on echo 2 of 3 -> en=0 next cycle, IDLE, no done pulse, echo_cnt=1; echoes=0 with 5 triggers -> no done, echo_cnt=5.
- With SD_ACQ_DDS_ALIGN_EN, delay=2, dds period 10 cycles with its rise 6 cycles after DELAY ends -> en rises exactly 1 cycle after the dds rise is detected; without the macro, dds toggling has no effect on timing.
